// File: rtl/alu_pkg.sv
// ALU operation codes and RV32I funct3/funct7 constants shared by the ALU,
// the operand stage and the existing operation wrappers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an OP / OP-IMM instruction into the ALU operation
// code, the shaped operand B and a malformed-encoding flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     is_imm,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  output logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    src_b,
  output logic                     illegal
);

  logic [6:0] imm_hi;
  logic       alt;

  assign imm_hi = imm[11:5];
  // Shift-immediates carry the arithmetic-shift selector in imm[10].
  assign alt    = is_imm ? imm[10] : funct7[5];

  always_comb begin
    op = ALU_ADD;
    unique case (funct3)
      F3_ADD_SUB: op = (!is_imm && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase

    illegal = 1'b0;
    if (is_imm) begin
      if (funct3 == F3_SLL && imm_hi != FUNCT7_BASE)
        illegal = 1'b1;
      if (funct3 == F3_SRL_SRA && imm_hi != FUNCT7_BASE && imm_hi != FUNCT7_ALT)
        illegal = 1'b1;
    end else begin
      if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
        illegal = 1'b1;
      else if (funct7 == FUNCT7_ALT && funct3 != F3_ADD_SUB && funct3 != F3_SRL_SRA)
        illegal = 1'b1;
    end
    if (illegal)
      op = ALU_ADD;

    src_b = '0;
    if (!is_imm)
      src_b = rs2_data;
    else if (is_shift(funct3))
      src_b[4:0] = imm[4:0];
    else
      src_b = imm;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-ALU pipeline stage: decodes the ALU operation on the input side
// and holds results in a main + skid register pair for full-rate handshaking.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_imm,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR_W-1:0]    out_rd,
  output logic                     out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                   state;
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic [DATA_WIDTH-1:0]    dec_src_b;
  logic                     dec_illegal;
  logic                     accept;
  logic                     consume;

  logic [DATA_WIDTH-1:0]    skid_src_a;
  logic [DATA_WIDTH-1:0]    skid_src_b;
  logic [OPCODE_LENGTH-1:0] skid_op;
  logic [REG_ADDR_W-1:0]    skid_rd;
  logic                     skid_illegal;

  alu_op_decode #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_decode (
    .is_imm  (in_is_imm),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rs2_data(in_rs2_data),
    .imm     (in_imm),
    .op      (dec_op),
    .src_b   (dec_src_b),
    .illegal (dec_illegal)
  );

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // The main register is the output register, so outputs stay stable
  // whenever execute stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      SrcA         <= '0;
      SrcB         <= '0;
      Operation    <= ALU_ADD;
      out_rd       <= '0;
      out_illegal  <= 1'b0;
      skid_src_a   <= '0;
      skid_src_b   <= '0;
      skid_op      <= ALU_ADD;
      skid_rd      <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            SrcA        <= in_rs1_data;
            SrcB        <= dec_src_b;
            Operation   <= dec_op;
            out_rd      <= in_rd;
            out_illegal <= dec_illegal;
            out_valid   <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            SrcA        <= in_rs1_data;
            SrcB        <= dec_src_b;
            Operation   <= dec_op;
            out_rd      <= in_rd;
            out_illegal <= dec_illegal;
          end else if (accept) begin
            skid_src_a   <= in_rs1_data;
            skid_src_b   <= dec_src_b;
            skid_op      <= dec_op;
            skid_rd      <= in_rd;
            skid_illegal <= dec_illegal;
            in_ready     <= 1'b0;
            state        <= FULL;
          end else if (consume) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            SrcA        <= skid_src_a;
            SrcB        <= skid_src_b;
            Operation   <= skid_op;
            out_rd      <= skid_rd;
            out_illegal <= skid_illegal;
            in_ready    <= 1'b1;
            state       <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a random
// handshake run scored against a queue-based model of the stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        is_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } res_t;

  logic [75:0] obs;
  assign obs = {out_valid, in_ready, Operation, SrcA, SrcB, out_rd, out_illegal};

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // Reference: what the ALU should see for one instruction, from the ISA rules.
  function automatic res_t model(input op_t o);
    logic [3:0] base [8];
    logic [6:0] hi;
    res_t r;
    base = '{4'b0010, 4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    hi   = o.imm[11:5];
    r.a  = o.rs1;
    r.rd = o.rd;
    r.op = base[o.f3];
    if (o.is_imm) begin
      r.ill = (o.f3 == 3'd1 && hi != 7'h00) || (o.f3 == 3'd5 && hi != 7'h00 && hi != 7'h20);
      if (o.f3 == 3'd5 && o.imm[10]) r.op = 4'b1011;
      r.b = (o.f3 == 3'd1 || o.f3 == 3'd5) ? {27'd0, o.imm[4:0]} : o.imm;
    end else begin
      r.ill = !(o.f7 == 7'h00 || (o.f7 == 7'h20 && (o.f3 == 3'd0 || o.f3 == 3'd5)));
      if (o.f7[5] && o.f3 == 3'd0) r.op = 4'b0110;
      if (o.f7[5] && o.f3 == 3'd5) r.op = 4'b1011;
      r.b = o.rs2;
    end
    if (r.ill) r.op = 4'b0010;
    return r;
  endfunction

  function automatic op_t mk(input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd);
    op_t o;
    o.is_imm = is_imm; o.f3 = f3; o.f7 = f7;
    o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.rd = rd;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  sel;
    o.is_imm = 1'($urandom_range(0, 1));
    o.f3     = 3'($urandom);
    sel      = int'($urandom_range(0, 3));
    o.f7     = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h00 : 7'($urandom);
    o.rs1    = $urandom;
    o.rs2    = $urandom;
    o.imm    = $urandom;
    sel      = int'($urandom_range(0, 3));
    if (sel == 0) o.imm[11:5] = 7'h00;
    if (sel == 1) o.imm[11:5] = 7'h20;
    o.rd     = 5'($urandom);
    return o;
  endfunction

  task automatic drive(input op_t o, input logic v);
    in_valid    = v;
    in_is_imm   = o.is_imm;
    in_funct3   = o.f3;
    in_funct7   = o.f7;
    in_rs1_data = o.rs1;
    in_rs2_data = o.rs2;
    in_imm      = o.imm;
    in_rd       = o.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 1'b1, 4'b0010, 70'd0});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (obs[75:74] !== 2'b01) begin
      n_fail++; $display("FAIL reset_idle: got valid/ready %b expected 01", obs[75:74]);
    end
  endtask

  task automatic test_srai();
    logic [75:0] e;
    out_ready = 1'b1;
    drive(mk(1'b1, 3'd5, 7'h00, 32'hF000_0000, 32'h1234_5678, 32'h0000_0404, 5'd3), 1'b1);
    tick();
    drive(rand_op(), 1'b0);
    e = {1'b1, 1'b1, 4'b1011, 32'hF000_0000, 32'h0000_0004, 5'd3, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL srai: got %h expected %h", obs, e); end
    $display("txn srai op=%b srcb=%h", Operation, SrcB);
    tick();
    n_checks++;
    if (obs[75:74] !== 2'b01) begin
      n_fail++; $display("FAIL srai_drain: got valid/ready %b expected 01", obs[75:74]);
    end
  endtask

  task automatic test_sub();
    logic [75:0] e;
    out_ready = 1'b1;
    drive(mk(1'b0, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFF, 5'd9), 1'b1);
    tick();
    drive(mk(1'b0, 3'd0, 7'h00, 32'd5, 32'd7, 32'hFFFF_FFFF, 5'd10), 1'b1);
    e = {1'b1, 1'b1, 4'b0110, 32'd5, 32'd7, 5'd9, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL sub: got %h expected %h", obs, e); end
    $display("txn sub op=%b rd=%0d", Operation, out_rd);
    tick();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 4'b0010, 32'd5, 32'd7, 5'd10, 1'b0};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL add_b2b: got %h expected %h", obs, e); end
    $display("txn add op=%b rd=%0d", Operation, out_rd);
    tick();
  endtask

  task automatic test_illegal();
    logic [75:0] e;
    out_ready = 1'b1;
    drive(mk(1'b1, 3'd1, 7'h00, 32'hA5A5_0001, 32'd0, 32'h0000_0C05, 5'd4), 1'b1);
    tick();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 4'b0010, 32'hA5A5_0001, 32'h0000_0005, 5'd4, 1'b1};
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL illegal_slli: got %h expected %h", obs, e); end
    $display("txn illegal op=%b ill=%b", Operation, out_illegal);
    tick();
  endtask

  task automatic test_backpressure();
    op_t a, b, c;
    a = rand_op(); b = rand_op(); c = rand_op();
    out_ready = 1'b1;
    drive(a, 1'b1);
    tick();
    n_checks++;
    if (obs !== {1'b1, 1'b1, model(a)}) begin
      n_fail++; $display("FAIL bp_a_first: got %h expected %h", obs, {1'b1, 1'b1, model(a)});
    end
    out_ready = 1'b0;
    drive(b, 1'b1);
    tick();
    n_checks++;
    if (obs !== {1'b1, 1'b0, model(a)}) begin
      n_fail++; $display("FAIL bp_a_held: got %h expected %h", obs, {1'b1, 1'b0, model(a)});
    end
    drive(c, 1'b1);
    tick();
    n_checks++;
    if (obs !== {1'b1, 1'b0, model(a)}) begin
      n_fail++; $display("FAIL bp_c_blocked: got %h expected %h", obs, {1'b1, 1'b0, model(a)});
    end
    $display("txn bp rd=%0d", out_rd);
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== {1'b1, 1'b1, model(b)}) begin
      n_fail++; $display("FAIL bp_b_out: got %h expected %h", obs, {1'b1, 1'b1, model(b)});
    end
    $display("txn bp rd=%0d", out_rd);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, model(c)}) begin
      n_fail++; $display("FAIL bp_c_out: got %h expected %h", obs, {1'b1, 1'b1, model(c)});
    end
    $display("txn bp rd=%0d", out_rd);
    tick();
    n_checks++;
    if (obs[75:74] !== 2'b01) begin
      n_fail++; $display("FAIL bp_drain: got valid/ready %b expected 01", obs[75:74]);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(rand_op(), 1'b1);
    tick();
    drive(rand_op(), 1'b1);
    tick();
    n_checks++;
    if (obs[75:74] !== 2'b10) begin
      n_fail++; $display("FAIL flush_full: got valid/ready %b expected 10", obs[75:74]);
    end
    // Make the stage ready again so the presented op would be taken without flush.
    out_ready = 1'b1;
    tick();
    drive(rand_op(), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (obs[75:74] !== 2'b01) begin
      n_fail++; $display("FAIL flush_clear: got valid/ready %b expected 01", obs[75:74]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs[75:74] !== 2'b01) begin
        n_fail++; $display("FAIL flush_no_ghost: cycle %0d got valid/ready %b expected 01", i, obs[75:74]);
      end
    end
  endtask

  task automatic test_async_reset();
    op_t a;
    a = rand_op();
    out_ready = 1'b0;
    drive(rand_op(), 1'b1);
    tick();
    drive(a, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 4'b0010, 70'd0}) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", obs, {1'b0, 1'b1, 4'b0010, 70'd0});
    end
    #2;
    reset = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, model(a)}) begin
      n_fail++; $display("FAIL post_reset_accept: got %h expected %h", obs, {1'b1, 1'b1, model(a)});
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    op_t  q[$];
    op_t  cur;
    res_t r;
    logic fl, av, cv;
    for (int i = 0; i < 400; i++) begin
      cur       = rand_op();
      drive(cur, ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      fl = flush;
      av = in_valid && (q.size() < 2);
      cv = out_ready && (q.size() != 0);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (cv) begin
          r = model(q[0]);
          $display("txn rand rd=%0d op=%b ill=%b", r.rd, r.op, r.ill);
          void'(q.pop_front());
        end
        if (av) q.push_back(cur);
      end
      n_checks++;
      if (q.size() == 0) begin
        if (obs[75:74] !== 2'b01) begin
          n_fail++; $display("FAIL rand_empty: cycle %0d got valid/ready %b expected 01", i, obs[75:74]);
        end
      end else begin
        if (obs !== {1'b1, (q.size() < 2), model(q[0])}) begin
          n_fail++; $display("FAIL rand_head: cycle %0d got %h expected %h", i, obs, {1'b1, (q.size() < 2), model(q[0])});
        end
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(mk(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0), 1'b0);
    test_reset();
    test_srai();
    test_sub();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Pipeline stage between instruction decode and the ALU. Registers one decoded integer operation per cycle, generates the 4-bit ALU operation code from opcode class/funct3/funct7, and selects and shapes operand B (immediate vs. rs2, shift-amount masking). A two-entry skid buffer gives full throughput under valid/ready backpressure from execute. Its outputs drive the ALU's SrcA, SrcB and Operation directly, including the SRA code used by shift-immediate instructions.

## Interface
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_W, 5, register index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  discard all held entries (branch redirect)
- in_valid  in  1  decode presents an operation
- in_ready  out  1  stage can accept; registered
- in_is_imm  in  1  1 = OP-IMM (I-type), 0 = OP (R-type)
- in_funct3  in  3  instruction funct3
- in_funct7  in  7  instruction funct7 (R-type only)
- in_rs1_data  in  DATA_WIDTH  rs1 value
- in_rs2_data  in  DATA_WIDTH  rs2 value
- in_imm  in  DATA_WIDTH  sign-extended I-immediate
- in_rd  in  REG_ADDR_W  destination register
- out_valid  out  1  SrcA/SrcB/Operation valid
- out_ready  in  1  execute consumes this cycle
- SrcA  out  DATA_WIDTH  ALU operand A (= rs1)
- SrcB  out  DATA_WIDTH  ALU operand B
- Operation  out  OPCODE_LENGTH  ALU operation code
- out_rd  out  REG_ADDR_W  destination register
- out_illegal  out  1  malformed encoding; Operation forced to ADD, rd write suppressed downstream

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1011.
- funct3 map: 000 ADD (SUB if R-type and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- Funct 101: R-type uses funct7[5]; I-type uses in_imm[10] (1 → SRA).
- SrcB: R-type → rs2_data; I-type shift (001/101) → zero-extended in_imm[4:0]; other I-type → in_imm.
- Illegal: I-type 001 with in_imm[11:5] ≠ 0; I-type 101 with in_imm[11:5] ∉ {0000000, 0100000}; R-type funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101}.
- Storage: main register (drives outputs) + skid register. States: EMPTY (main empty), ONE (main full), FULL (main + skid full).
- EMPTY: accept → ONE. ONE: accept & consume → ONE; accept only → FULL; consume only → EMPTY. FULL: consume → skid moves to main, ONE; no input accepted.
- in_ready = (state ≠ FULL), registered; accept = in_valid & in_ready; consume = out_valid & out_ready.
- Order strictly preserved.

## Timing
- Latency: accepted at edge N → on outputs with out_valid after edge N.
- Throughput: one op/cycle while out_ready high.
- Outputs stable while out_valid & !out_ready.
- flush: at next edge both entries invalidated, state EMPTY, in_ready 1; input presented that cycle is discarded even if in_valid & in_ready; flush dominates accept/consume.
- Reset (any time, mid-transfer included): state EMPTY, out_valid 0, in_ready 1, SrcA/SrcB/out_rd 0, Operation 0010, out_illegal 0.

## Structure
- Package alu_pkg: ALU code constants (above), funct3 constants, FUNCT7_ALT = 7'b0100000; shared with the ALU and existing operation wrappers.
- One sub-module: alu_op_decode (combinational: is_imm/funct3/funct7/imm → Operation, SrcB select, illegal); the stage instantiates it once on the input side and registers its results.

## Test plan
- SRAI: is_imm=1, funct3=101, imm=0x00000404, rs1=0xF0000000 → next cycle Operation=1011, SrcB=0x00000004, SrcA=0xF0000000, out_illegal=0.
- R-type SUB: funct3=000, funct7=0x20, rs1=5, rs2=7 → Operation=0110, SrcB=7; same with funct7=0 → 0010.
- Backpressure: stream ops A,B,C with out_ready=0 from cycle after A → A held, B in skid, in_ready=0, C not accepted; raise out_ready → A,B,C emerge in order, no loss or duplicate.
- Illegal: is_imm=1, funct3=001, imm=0x00000C05 → out_illegal=1, Operation=0010.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed and presented ops never appear.
- Reset asserted mid-stream (async, between edges) → out_valid=0, Operation=0010, in_ready=1 immediately; clean acceptance after release.
